// File: rtl/dbg_frame_pkg.sv
// Shared definitions for the debug-bridge frame generator: command bytes,
// FSM state type and the word-to-byte selection helper.
package dbg_frame_pkg;

    localparam logic [7:0] CMD_WRITE = 8'h10;
    localparam logic [7:0] CMD_READ  = 8'h11;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CMD   = 3'd1,
        ST_LEN   = 3'd2,
        ST_ADDR  = 3'd3,
        ST_FETCH = 3'd4,
        ST_DATA  = 3'd5,
        ST_DONE  = 3'd6
    } frame_state_t;

    // Select byte idx of a 32-bit word, index 0 being the most significant byte.
    function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = w[31:24];
            2'd1:    b = w[23:16];
            2'd2:    b = w[15:8];
            2'd3:    b = w[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/dbg_frame_gen.sv
// Streams a block of 32-bit words into the debug-bridge TX byte FIFO as
// write-command frames: CMD_WRITE, LEN, ADDR (MSB first), then data bytes.
// Long transfers are split into frames of WORDS_PER_FRAME words.
module dbg_frame_gen
    import dbg_frame_pkg::*;
#(
    parameter int WORDS_PER_FRAME = 4,
    parameter int CNT_W           = 16
) (
    input  logic             fclk,
    input  logic             fpga_reset_n,
    input  logic             start_i,
    input  logic [31:0]      base_addr_i,
    input  logic [CNT_W-1:0] word_cnt_i,
    output logic             busy_o,
    output logic             done_o,
    input  logic             word_valid_i,
    input  logic [31:0]      word_data_i,
    output logic             word_ready_o,
    output logic             byte_valid_o,
    output logic [7:0]       byte_data_o,
    input  logic             byte_accept_i
);

    localparam int FW_W = $clog2(WORDS_PER_FRAME + 1);

    frame_state_t     state_q, state_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             word_ready_q, word_ready_d;
    logic             byte_valid_q, byte_valid_d;
    logic [7:0]       byte_data_q, byte_data_d;
    logic [31:0]      addr_q, addr_d;
    logic [CNT_W-1:0] remaining_q, remaining_d;
    logic [FW_W-1:0]  frame_left_q, frame_left_d;
    logic [7:0]       len_q, len_d;
    logic [1:0]       byte_idx_q, byte_idx_d;
    logic [31:0]      word_q, word_d;

    logic [FW_W-1:0]  frame_words_s;
    logic [7:0]       len_s;
    logic             byte_acc_s;
    logic             word_hs_s;

    assign frame_words_s = (remaining_q > CNT_W'(WORDS_PER_FRAME)) ? FW_W'(WORDS_PER_FRAME)
                                                                   : FW_W'(remaining_q);
    assign len_s         = 8'({frame_words_s, 2'b00});
    assign byte_acc_s    = byte_valid_q && byte_accept_i;
    assign word_hs_s     = word_ready_q && word_valid_i;

    // Next-state, next-output and counter update logic for the framing FSM.
    always_comb begin
        state_d      = state_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        word_ready_d = word_ready_q;
        byte_valid_d = byte_valid_q;
        byte_data_d  = byte_data_q;
        addr_d       = addr_q;
        remaining_d  = remaining_q;
        frame_left_d = frame_left_q;
        len_d        = len_q;
        byte_idx_d   = byte_idx_q;
        word_d       = word_q;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    busy_d = 1'b1;
                    if (word_cnt_i != {CNT_W{1'b0}}) begin
                        addr_d       = base_addr_i;
                        remaining_d  = word_cnt_i;
                        state_d      = ST_CMD;
                        byte_valid_d = 1'b1;
                        byte_data_d  = CMD_WRITE;
                    end else begin
                        // Empty transfer: pass through DONE without emitting bytes.
                        state_d = ST_DONE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_CMD: begin
                if (byte_acc_s) begin
                    state_d      = ST_LEN;
                    byte_data_d  = len_s;
                    len_d        = len_s;
                    frame_left_d = frame_words_s;
                end else begin
                    state_d = ST_CMD;
                end
            end

            ST_LEN: begin
                if (byte_acc_s) begin
                    state_d     = ST_ADDR;
                    byte_idx_d  = 2'd0;
                    byte_data_d = word_byte(addr_q, 2'd0);
                end else begin
                    state_d = ST_LEN;
                end
            end

            ST_ADDR: begin
                if (byte_acc_s) begin
                    if (byte_idx_q == 2'd3) begin
                        state_d      = ST_FETCH;
                        byte_valid_d = 1'b0;
                        word_ready_d = 1'b1;
                    end else begin
                        byte_idx_d  = byte_idx_q + 2'd1;
                        byte_data_d = word_byte(addr_q, byte_idx_q + 2'd1);
                    end
                end else begin
                    state_d = ST_ADDR;
                end
            end

            ST_FETCH: begin
                if (word_hs_s) begin
                    state_d      = ST_DATA;
                    word_d       = word_data_i;
                    word_ready_d = 1'b0;
                    byte_valid_d = 1'b1;
                    byte_data_d  = word_byte(word_data_i, 2'd0);
                    byte_idx_d   = 2'd0;
                    remaining_d  = remaining_q - CNT_W'(1'b1);
                    frame_left_d = frame_left_q - FW_W'(1'b1);
                end else begin
                    state_d = ST_FETCH;
                end
            end

            ST_DATA: begin
                if (byte_acc_s) begin
                    if (byte_idx_q == 2'd3) begin
                        byte_valid_d = 1'b0;
                        if (frame_left_q != {FW_W{1'b0}}) begin
                            state_d      = ST_FETCH;
                            word_ready_d = 1'b1;
                        end else if (remaining_q != {CNT_W{1'b0}}) begin
                            // Next frame starts right after this one; address wraps silently.
                            state_d      = ST_CMD;
                            addr_d       = addr_q + {24'h000000, len_q};
                            byte_valid_d = 1'b1;
                            byte_data_d  = CMD_WRITE;
                        end else begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
                        end
                    end else begin
                        byte_idx_d  = byte_idx_q + 2'd1;
                        byte_data_d = word_byte(word_q, byte_idx_q + 2'd1);
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end

            ST_DONE: begin
                // done_q already high means the pulse is on the outputs now.
                if (done_q) begin
                    state_d = ST_IDLE;
                end else begin
                    done_d = 1'b1;
                    busy_d = 1'b0;
                end
            end

            default: begin
                state_d      = ST_IDLE;
                busy_d       = 1'b0;
                word_ready_d = 1'b0;
                byte_valid_d = 1'b0;
                byte_data_d  = 8'h00;
            end
        endcase
    end

    // State, counter and registered-output flops with asynchronous reset.
    always_ff @(posedge fclk or negedge fpga_reset_n) begin
        if (!fpga_reset_n) begin
            state_q      <= ST_IDLE;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            word_ready_q <= 1'b0;
            byte_valid_q <= 1'b0;
            byte_data_q  <= 8'h00;
            addr_q       <= 32'h00000000;
            remaining_q  <= {CNT_W{1'b0}};
            frame_left_q <= {FW_W{1'b0}};
            len_q        <= 8'h00;
            byte_idx_q   <= 2'd0;
            word_q       <= 32'h00000000;
        end else begin
            state_q      <= state_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            word_ready_q <= word_ready_d;
            byte_valid_q <= byte_valid_d;
            byte_data_q  <= byte_data_d;
            addr_q       <= addr_d;
            remaining_q  <= remaining_d;
            frame_left_q <= frame_left_d;
            len_q        <= len_d;
            byte_idx_q   <= byte_idx_d;
            word_q       <= word_d;
        end
    end

    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign word_ready_o = word_ready_q;
    assign byte_valid_o = byte_valid_q;
    assign byte_data_o  = byte_data_q;

endmodule

// File: tb/tb_dbg_frame_gen.sv
// Scoreboard bench for dbg_frame_gen: a frame-level reference model queues the
// expected byte stream per transfer; a negedge monitor pops and compares each
// accepted byte and checks the handshake rules.
module tb_dbg_frame_gen;

    localparam int W = 4;

    logic        fclk = 1'b0;
    logic        fpga_reset_n = 1'b0;
    logic        start_i = 1'b0;
    logic [31:0] base_addr_i = 32'h0;
    logic [15:0] word_cnt_i = 16'h0;
    logic        busy_o, done_o;
    logic        word_valid_i = 1'b0;
    logic [31:0] word_data_i = 32'h0;
    logic        word_ready_o;
    logic        byte_valid_o;
    logic [7:0]  byte_data_o;
    logic        byte_accept_i = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int done_cnt = 0;
    int acc_pct  = 100;
    int word_delay_cfg = 0;

    logic [7:0]  exp_q[$];
    logic [31:0] words_q[$];

    dbg_frame_gen #(.WORDS_PER_FRAME(W), .CNT_W(16)) dut (
        .fclk(fclk), .fpga_reset_n(fpga_reset_n),
        .start_i(start_i), .base_addr_i(base_addr_i), .word_cnt_i(word_cnt_i),
        .busy_o(busy_o), .done_o(done_o),
        .word_valid_i(word_valid_i), .word_data_i(word_data_i), .word_ready_o(word_ready_o),
        .byte_valid_o(byte_valid_o), .byte_data_o(byte_data_o), .byte_accept_i(byte_accept_i)
    );

    always #5 fclk = ~fclk;

    always @(posedge fclk) cyc++;

    task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    endtask

    // Reference model: split into frames, emit header and MSB-first data bytes.
    task automatic model(input logic [31:0] base, input int cnt, input logic [31:0] w[$]);
        int rem = cnt;
        int idx = 0;
        logic [31:0] a = base;
        while (rem > 0) begin
            int n = (rem < W) ? rem : W;
            exp_q.push_back(8'h10);
            exp_q.push_back(8'(4 * n));
            for (int k = 3; k >= 0; k--) exp_q.push_back(8'(a >> (8 * k)));
            for (int j = 0; j < n; j++) begin
                for (int k = 3; k >= 0; k--) exp_q.push_back(8'(w[idx] >> (8 * k)));
                idx++;
            end
            a   = a + 32'(4 * n);
            rem = rem - n;
        end
    endtask

    // Byte sink: accept with the configured probability.
    always @(posedge fclk) begin
        #1;
        byte_accept_i = ($urandom_range(99) < acc_pct);
    end

    // Word source: present queued words, optionally after word_ready_o has been high a while.
    logic w_fire = 1'b0;
    logic rdy_seen = 1'b0;
    int   wait_cnt = 0;
    always @(negedge fclk) begin
        w_fire   = word_valid_i && word_ready_o;
        rdy_seen = word_ready_o;
    end
    always @(posedge fclk) begin
        #1;
        if (!fpga_reset_n) begin
            word_valid_i = 1'b0;
            wait_cnt     = 0;
        end else begin
            if (w_fire) begin
                if (words_q.size() > 0) void'(words_q.pop_front());
                word_valid_i = 1'b0;
                wait_cnt     = 0;
                w_fire       = 1'b0;
            end
            if (!word_valid_i && words_q.size() > 0) begin
                if (wait_cnt >= word_delay_cfg) begin
                    word_valid_i = 1'b1;
                    word_data_i  = words_q[0];
                end else if (rdy_seen) begin
                    wait_cnt++;
                end
            end
        end
    end

    // Monitor: compare accepted bytes against the scoreboard and check handshake rules.
    logic       prev_v = 1'b0, prev_a = 1'b0;
    logic [7:0] prev_d = 8'h00;
    always @(negedge fclk) begin
        if (!fpga_reset_n) begin
            prev_v = 1'b0;
            prev_a = 1'b0;
        end else begin
            if (prev_v && !prev_a)
                chk(byte_valid_o && (byte_data_o == prev_d), "byte_hold", {55'd0, byte_valid_o, byte_data_o}, {55'd0, 1'b1, prev_d});
            if (byte_valid_o && byte_accept_i) begin
                if (exp_q.size() == 0) begin
                    chk(1'b0, "unexpected_byte", byte_data_o, 0);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    chk(byte_data_o == e, "byte", byte_data_o, e);
                    chk(busy_o == 1'b1, "busy_during_byte", busy_o, 1);
                end
            end
            if (word_ready_o)
                chk(byte_valid_o == 1'b0, "valid_low_in_fetch", byte_valid_o, 0);
            if (done_o) done_cnt++;
            prev_v = byte_valid_o;
            prev_a = byte_accept_i;
            prev_d = byte_data_o;
        end
    end

    task automatic run_xfer(input logic [31:0] base, input int cnt, input int pct, input int wdelay,
                            input bit use_first, input logic [31:0] first_word);
        logic [31:0] w[$];
        int d0;
        int k;
        acc_pct        = pct;
        word_delay_cfg = wdelay;
        for (int i = 0; i < cnt; i++) w.push_back((i == 0 && use_first) ? first_word : $urandom());
        model(base, cnt, w);
        foreach (w[i]) words_q.push_back(w[i]);
        d0 = done_cnt;
        @(posedge fclk); #1;
        start_i = 1'b1; base_addr_i = base; word_cnt_i = 16'(cnt);
        @(posedge fclk); #1;
        start_i = 1'b0; base_addr_i = $urandom(); word_cnt_i = 16'($urandom_range(1, 9));
        @(negedge fclk);
        chk(busy_o == 1'b1, "busy_after_start", busy_o, 1);
        // A start while busy must be ignored.
        @(posedge fclk); #1;
        start_i = 1'b1;
        @(posedge fclk); #1;
        start_i = 1'b0;
        k = 0;
        while (!done_o && k < 4000) begin
            @(negedge fclk);
            k++;
        end
        chk(done_o == 1'b1, "done_seen", done_o, 1);
        chk(busy_o == 1'b0, "busy_low_at_done", busy_o, 0);
        chk(exp_q.size() == 0, "bytes_outstanding", exp_q.size(), 0);
        chk(words_q.size() == 0, "words_outstanding", words_q.size(), 0);
        @(negedge fclk);
        chk(done_o == 1'b0, "done_single_cycle", done_o, 0);
        repeat (3) @(negedge fclk);
        chk(busy_o == 1'b0, "idle_not_busy", busy_o, 0);
        chk(done_cnt - d0 == 1, "done_pulse_count", done_cnt - d0, 1);
    endtask

    initial begin : hang_guard
        #2000000;
        $display("FAIL timeout: simulation limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        int c0;
        int k;
        int vseen;
        int d0;
        logic [31:0] w[$];

        // Reset state
        #2;
        chk(busy_o == 1'b0, "rst_busy", busy_o, 0);
        chk(done_o == 1'b0, "rst_done", done_o, 0);
        chk(word_ready_o == 1'b0, "rst_ready", word_ready_o, 0);
        chk(byte_valid_o == 1'b0, "rst_valid", byte_valid_o, 0);
        chk(byte_data_o == 8'h00, "rst_data", byte_data_o, 0);
        #10 fpga_reset_n = 1'b1;
        repeat (2) @(posedge fclk);

        // 1: single full frame, always accept
        run_xfer(32'h0, 4, 100, 0, 1'b0, 32'h0);
        // 2: two frames, second partial
        run_xfer(32'h2000, 5, 100, 0, 1'b0, 32'h0);
        // 3: randomized back-pressure
        run_xfer(32'h0, 4, 50, 0, 1'b0, 32'h0);

        // 4: zero-length transfer
        acc_pct = 100;
        d0 = done_cnt;
        @(posedge fclk); #1;
        start_i = 1'b1; base_addr_i = 32'h55; word_cnt_i = 16'd0;
        c0 = cyc;
        @(posedge fclk); #1;
        word_cnt_i = 16'd4;  // start still high, now with a count: must be ignored
        @(negedge fclk);
        chk(done_o == 1'b0, "zero_done_early", done_o, 0);
        @(posedge fclk); #1;
        start_i = 1'b0;
        @(negedge fclk);
        chk(done_o == 1'b1, "zero_done", done_o, 1);
        chk(cyc - c0 == 2, "zero_done_latency", cyc - c0, 2);
        vseen = 0;
        repeat (10) begin
            @(negedge fclk);
            if (byte_valid_o) vseen++;
        end
        chk(vseen == 0, "zero_no_bytes", vseen, 0);
        chk(done_cnt - d0 == 1, "zero_done_count", done_cnt - d0, 1);

        // 5: reset during ADDR bytes, then fresh transfer
        acc_pct = 100;
        word_delay_cfg = 0;
        for (int i = 0; i < 3; i++) w.push_back($urandom());
        model(32'h12345678, 3, w);
        foreach (w[i]) words_q.push_back(w[i]);
        @(posedge fclk); #1;
        start_i = 1'b1; base_addr_i = 32'h12345678; word_cnt_i = 16'd3;
        @(posedge fclk); #1;
        start_i = 1'b0;
        k = 0;
        while (exp_q.size() > 4 + 12 && k < 100) begin
            @(negedge fclk);
            k++;
        end
        chk(k < 100, "reset_wait", k, 100);
        @(posedge fclk); #2;
        fpga_reset_n = 1'b0;
        #1;
        chk(busy_o == 1'b0, "mid_rst_busy", busy_o, 0);
        chk(byte_valid_o == 1'b0, "mid_rst_valid", byte_valid_o, 0);
        chk(byte_data_o == 8'h00, "mid_rst_data", byte_data_o, 0);
        chk(word_ready_o == 1'b0, "mid_rst_ready", word_ready_o, 0);
        chk(done_o == 1'b0, "mid_rst_done", done_o, 0);
        exp_q.delete();
        words_q.delete();
        repeat (2) @(posedge fclk);
        #3 fpga_reset_n = 1'b1;
        run_xfer(32'h40, 2, 100, 0, 1'b0, 32'h0);

        // 6: slow word source
        run_xfer(32'h100, 1, 100, 7, 1'b1, 32'hDEADBEEF);

        // Random transfers, including address wrap
        run_xfer(32'hFFFF_FFF8, 6, 70, 1, 1'b0, 32'h0);
        for (int t = 0; t < 5; t++)
            run_xfer($urandom(), $urandom_range(1, 11), $urandom_range(30, 100), $urandom_range(0, 3), 1'b0, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
